cm0_acg_ctrl: RTL and testbench



---
 rtl/cm0_acg_ctrl_pkg.sv | 22 ++
 rtl/cm0_acg_dncnt.sv | 28 ++
 rtl/cm0_acg_ctrl.sv | 116 +++++++++++
 tb/tb_cm0_acg_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cm0_acg_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the clock-gate enable sequencer.
// The state encoding is fixed so that the debug state output decodes the same way in every domain.
package cm0_acg_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HYST = 2'd1,
      OFF  = 2'd2,
      WAKE = 2'd3
   } acg_state_e;

   // Both countdowns preload (cycles-1), so each may be as large as 2^cntw.
   function automatic logic acg_params_ok(input int idle_cycles, input int wake_cycles,
                                          input int cntw);
      longint lim;
      lim = longint'(64'd1 << cntw);
      return (cntw >= 1) && (cntw <= 31) &&
             (idle_cycles >= 1) && (longint'(idle_cycles) <= lim) &&
             (wake_cycles >= 1) && (longint'(wake_cycles) <= lim);
   endfunction

endpackage

// File: rtl/cm0_acg_dncnt.sv
// Loadable down-counter shared by the idle-hysteresis and wake-settle phases.
// Load has priority over decrement, and the count saturates at zero.
module cm0_acg_dncnt #(
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            dec,
   input  logic [CNTW-1:0] load_val,
   output logic            zero
);

   logic [CNTW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/cm0_acg_ctrl.sv
// Enable sequencer for one architectural clock-gate cell: hysteresis before gating off,
// and a fixed settle time before acknowledging a wake request. Runs on the ungated clock.
module cm0_acg_ctrl
   import cm0_acg_ctrl_pkg::*;
#(
   parameter logic ACG         = 1'b1,
   parameter int   IDLE_CYCLES = 16,
   parameter int   WAKE_CYCLES = 2,
   parameter int   CNTW        = 8
) (
   input  logic       CLKIN,
   input  logic       RESET,
   input  logic       BUSY,
   input  logic       FORCEON,
   input  logic       WAKEREQ,
   output logic       WAKEACK,
   output logic       GATEEN,
   output logic       GATED,
   output logic [1:0] state_dbg
);

   // Handshake: WAKEREQ rises and holds until WAKEACK rises; WAKEREQ then falls and WAKEACK
   // follows one edge later. A request withdrawn before its acknowledge is simply dropped.

   generate
      if (!acg_params_ok(IDLE_CYCLES, WAKE_CYCLES, CNTW)) begin : g_bad_params
         $error("cm0_acg_ctrl: IDLE_CYCLES/WAKE_CYCLES must lie in 1..2**CNTW");
      end
   endgenerate

   localparam logic [CNTW-1:0] IDLE_LD = CNTW'(IDLE_CYCLES - 1);
   localparam logic [CNTW-1:0] WAKE_LD = CNTW'(WAKE_CYCLES - 1);

   acg_state_e      state;
   acg_state_e      next_state;
   logic            keep;
   logic            cnt_load;
   logic            cnt_dec;
   logic            cnt_zero;
   logic [CNTW-1:0] cnt_load_val;
   logic            gateen_d;
   logic            gated_d;
   logic            wakeack_d;

   assign keep      = BUSY | FORCEON | WAKEREQ;
   assign state_dbg = state;

   cm0_acg_dncnt #(.CNTW(CNTW)) u_dncnt (
      .clk      (CLKIN),
      .rst      (RESET),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_load_val),
      .zero     (cnt_zero)
   );

   // Reset forces the clock on without waiting for an edge.
   always_ff @(posedge CLKIN or posedge RESET) begin
      if (RESET) begin
         state   <= RUN;
         GATEEN  <= 1'b1;
         GATED   <= 1'b0;
         WAKEACK <= 1'b0;
      end else begin
         state   <= next_state;
         GATEEN  <= gateen_d;
         GATED   <= gated_d;
         WAKEACK <= wakeack_d;
      end
   end

   always_comb begin
      next_state   = state;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      cnt_load_val = IDLE_LD;
      if (ACG) begin
         case (state)
            RUN: begin
               if (!keep) begin
                  next_state = HYST;
                  cnt_load   = 1'b1;
               end
            end
            // Fresh activity wins over an expiring countdown.
            HYST: begin
               if (keep)          next_state = RUN;
               else if (cnt_zero) next_state = OFF;
               else               cnt_dec    = 1'b1;
            end
            OFF: begin
               if (keep) begin
                  next_state   = WAKE;
                  cnt_load     = 1'b1;
                  cnt_load_val = WAKE_LD;
               end
            end
            // Activity is ignored while the clock settles; RUN re-evaluates it next edge.
            WAKE: begin
               if (cnt_zero) next_state = RUN;
               else          cnt_dec    = 1'b1;
            end
            default: next_state = RUN;
         endcase
      end else begin
         next_state = RUN;
      end
   end

   always_comb begin
      gateen_d  = (next_state != OFF);
      gated_d   = (next_state == OFF) || (next_state == WAKE);
      wakeack_d = WAKEREQ && (state == RUN);
   end

endmodule

// File: tb/tb_cm0_acg_ctrl.sv
// Bench for cm0_acg_ctrl: three instances (defaults, ACG=0, one-cycle countdowns) share stimulus
// and are compared every cycle against an activity-counting reference model.
module tb_cm0_acg_ctrl;

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_HYST = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;
   localparam logic [1:0] S_WAKE = 2'd3;

   localparam int M_RUNNING = 0;
   localparam int M_OFF     = 1;
   localparam int M_WAKING  = 2;

   typedef struct {
      logic       b;
      logic       f;
      logic       w;
      int         reps;
      logic [4:0] exp;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       busy;
   logic       forceon;
   logic       wakereq;
   logic [2:0] ge;
   logic [2:0] gd;
   logic [2:0] ack;
   logic [1:0] st [3];

   int         n_tests;
   int         n_fail;
   logic [4:0] exp_q[$];
   vec_t       tbl[$];

   // model: per instance, running/off/waking plus counts of idle samples and wake edges
   int   m_mode [3];
   int   m_idle [3];
   int   m_wk   [3];
   logic m_ack  [3];
   int   m_i    [3] = '{16, 16, 1};
   int   m_w    [3] = '{2, 2, 1};
   logic m_acg  [3] = '{1'b1, 1'b0, 1'b1};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   cm0_acg_ctrl dut0 (
      .CLKIN(clk), .RESET(rst), .BUSY(busy), .FORCEON(forceon), .WAKEREQ(wakereq),
      .WAKEACK(ack[0]), .GATEEN(ge[0]), .GATED(gd[0]), .state_dbg(st[0])
   );

   cm0_acg_ctrl #(.ACG(1'b0)) dut1 (
      .CLKIN(clk), .RESET(rst), .BUSY(busy), .FORCEON(forceon), .WAKEREQ(wakereq),
      .WAKEACK(ack[1]), .GATEEN(ge[1]), .GATED(gd[1]), .state_dbg(st[1])
   );

   cm0_acg_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1)) dut2 (
      .CLKIN(clk), .RESET(rst), .BUSY(busy), .FORCEON(forceon), .WAKEREQ(wakereq),
      .WAKEACK(ack[2]), .GATEEN(ge[2]), .GATED(gd[2]), .state_dbg(st[2])
   );

   function automatic logic [4:0] act_vec(input int i);
      return {st[i], ge[i], gd[i], ack[i]};
   endfunction

   function automatic logic [4:0] model_vec(input int i);
      logic [1:0] s;
      if (m_mode[i] == M_OFF)         s = S_OFF;
      else if (m_mode[i] == M_WAKING) s = S_WAKE;
      else if (m_idle[i] > 0)         s = S_HYST;
      else                            s = S_RUN;
      return {s, m_mode[i] != M_OFF, m_mode[i] != M_RUNNING, m_ack[i]};
   endfunction

   function automatic vec_t mk(input logic b, input logic f, input logic w, input int reps,
                               input logic [1:0] s, input logic g_en, input logic g_d,
                               input logic a);
      vec_t v;
      v.b = b; v.f = f; v.w = w; v.reps = reps;
      v.exp = {s, g_en, g_d, a};
      return v;
   endfunction

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got st/ge/gd/ack=%b required %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_mode[i] = M_RUNNING;
         m_idle[i] = 0;
         m_wk[i]   = 0;
         m_ack[i]  = 1'b0;
      end
   endtask

   task automatic model_step(input logic k, input logic wreq);
      for (int i = 0; i < 3; i++) begin
         if (!m_acg[i]) begin
            m_ack[i] = wreq;
         end else begin
            m_ack[i] = wreq && (m_mode[i] == M_RUNNING) && (m_idle[i] == 0);
            if (m_mode[i] == M_RUNNING) begin
               m_idle[i] = k ? 0 : m_idle[i] + 1;
               if (m_idle[i] == m_i[i] + 1) begin
                  m_mode[i] = M_OFF;
                  m_idle[i] = 0;
               end
            end else if (m_mode[i] == M_OFF) begin
               if (k) begin
                  m_mode[i] = M_WAKING;
                  m_wk[i]   = 0;
               end
            end else begin
               m_wk[i]++;
               if (m_wk[i] == m_w[i]) m_mode[i] = M_RUNNING;
            end
         end
      end
   endtask

   task automatic score();
      logic [4:0] e;
      for (int i = 0; i < 3; i++) exp_q.push_back(model_vec(i));
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         chk($sformatf("model[%0d]", i), act_vec(i), e);
      end
   endtask

   // driver: called just after a falling edge, returns just after the next falling edge
   task automatic tick(input logic b, input logic f, input logic w);
      busy = b; forceon = f; wakereq = w;
      @(posedge clk);
      #1;
      model_step(b | f | w, w);
      score();
      @(negedge clk);
   endtask

   // asynchronous reset pulse placed entirely between two rising edges
   task automatic rst_pulse(input string name);
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("%s[%0d]", name, i), act_vec(i), {S_RUN, 3'b100});
      #1 rst = 1'b0;
      model_reset();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1; busy = 1'b0; forceon = 1'b0; wakereq = 1'b0;
      model_reset();
      #2;
      for (int i = 0; i < 3; i++) chk($sformatf("reset[%0d]", i), act_vec(i), {S_RUN, 3'b100});
      @(negedge clk);
      rst = 1'b0;

      // directed table against the default instance
      tbl.push_back(mk(1, 0, 0, 3,  S_RUN,  1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16, S_HYST, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1,  S_OFF,  0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 5,  S_OFF,  0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1,  S_WAKE, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1,  S_WAKE, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1,  S_RUN,  1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1,  S_RUN,  1, 0, 1));
      tbl.push_back(mk(0, 0, 1, 2,  S_RUN,  1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1,  S_HYST, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 10, S_HYST, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1,  S_RUN,  1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16, S_HYST, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1,  S_RUN,  1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 17, S_OFF,  0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 1,  S_WAKE, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  S_WAKE, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  S_RUN,  1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1,  S_HYST, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 16, S_OFF,  0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1,  S_WAKE, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 2,  S_RUN,  1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1,  S_HYST, 1, 0, 0));
      for (int t = 0; t < tbl.size(); t++) begin
         for (int r = 0; r < tbl[t].reps; r++) tick(tbl[t].b, tbl[t].f, tbl[t].w);
         chk($sformatf("tbl[%0d]", t), act_vec(0), tbl[t].exp);
      end

      // asynchronous reset while OFF
      for (int r = 0; r < 17; r++) tick(0, 0, 0);
      chk("pre_off", act_vec(0), {S_OFF, 3'b010});
      rst_pulse("rst_off");
      tick(1, 0, 0);
      chk("post_rst_off", act_vec(0), {S_RUN, 3'b100});

      // asynchronous reset while WAKE, then request served directly from RUN
      for (int r = 0; r < 17; r++) tick(0, 0, 0);
      tick(0, 0, 1);
      chk("pre_wake", act_vec(0), {S_WAKE, 3'b110});
      rst_pulse("rst_wake");
      tick(0, 0, 1);
      chk("req_in_run", act_vec(0), {S_RUN, 3'b101});
      rst_pulse("rst_ack");
      tick(0, 0, 0);

      // random idle bursts separated by short activity
      for (int s = 0; s < 40; s++) begin
         int idle_len;
         int act_len;
         idle_len = $urandom_range(0, 20);
         act_len  = $urandom_range(1, 4);
         for (int r = 0; r < idle_len; r++) tick(0, 0, 0);
         for (int r = 0; r < act_len; r++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)));
      end

      // dense random toggling
      for (int r = 0; r < 200; r++)
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
